// File: rtl/led_pattern_sequencer_pkg.sv
// Shared types and helpers for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_FILL_CLEAR = 2'd0,
    MODE_FILL_DRAIN = 2'd1,
    MODE_WALK       = 2'd2,
    MODE_BLINK      = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WALK  = 2'd2,
    ST_BLINK = 2'd3
  } state_t;

  // Widest LED bank the start-value helper can describe.
  localparam int unsigned MAX_WIDTH = 64;

  // Pattern value a mode begins its cycle with: a single lit LED for WALK,
  // all LEDs dark for everything else.
  function automatic logic [MAX_WIDTH-1:0] start_value(input mode_t m);
    logic [MAX_WIDTH-1:0] v;
    v = '0;
    if (m == MODE_WALK) v[0] = 1'b1;
    return v;
  endfunction

  // FSM state a mode begins its cycle in.
  function automatic state_t entry_state(input mode_t m);
    state_t s;
    case (m)
      MODE_WALK:  s = ST_WALK;
      MODE_BLINK: s = ST_BLINK;
      default:    s = ST_FILL;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_pattern_sequencer_if.sv
// Mode-request and LED-output bundle between the debouncer, the sequencer
// and the LED pins.
interface led_pattern_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             EN;
  logic [1:0]       MODE;
  logic             MODE_REQ;
  logic [WIDTH-1:0] Q;
  logic             PENDING;
  logic             CYCLE_DONE;

  modport master (
    output EN, MODE, MODE_REQ,
    input  Q, PENDING, CYCLE_DONE
  );

  modport slave (
    input  EN, MODE, MODE_REQ,
    output Q, PENDING, CYCLE_DONE
  );
endinterface

// File: rtl/led_pattern_sequencer_prescaler.sv
// Step prescaler: one TICK every DIV enabled cycles; count holds while EN=0.
module step_prescaler #(
  parameter int unsigned DIV = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  output logic TICK
);
  localparam int unsigned   CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign TICK = EN && (cnt == LAST);

  // Cycle counter 0..DIV-1, advanced only while enabled.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (TICK) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/led_pattern_sequencer.sv
// Mode-selectable LED pattern sequencer. Mode changes are queued and only
// applied at a pattern-cycle boundary so a sweep is never cut short.
module led_pattern_sequencer
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  led_pattern_sequencer_if.slave bus
);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] LSB_ONLY = WIDTH'(1);
  localparam logic [WIDTH-1:0] MSB_ONLY = LSB_ONLY << (WIDTH - 1);

  state_t           state, state_n;
  mode_t            active_mode, active_mode_n;
  mode_t            pending_mode, pending_mode_n;
  mode_t            next_mode;
  logic             pending, pending_n;
  logic [WIDTH-1:0] q, q_n;
  logic             done, done_n;
  logic             tick;
  logic             boundary;

  step_prescaler #(.DIV(DIV)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (bus.EN),
    .TICK (tick)
  );

  // State, pattern, pending request and cycle-done registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= ST_FILL;
      active_mode  <= MODE_FILL_CLEAR;
      pending_mode <= MODE_FILL_CLEAR;
      pending      <= 1'b0;
      q            <= '0;
      done         <= 1'b0;
    end else begin
      state        <= state_n;
      active_mode  <= active_mode_n;
      pending_mode <= pending_mode_n;
      pending      <= pending_n;
      q            <= q_n;
      done         <= done_n;
    end
  end

  // Next pattern step, boundary detection and request queueing.
  always_comb begin
    state_n        = state;
    active_mode_n  = active_mode;
    pending_mode_n = pending_mode;
    pending_n      = pending;
    q_n            = q;
    done_n         = 1'b0;
    boundary       = 1'b0;
    next_mode      = active_mode;

    if (tick) begin
      case (state)
        ST_FILL: begin
          if (q == ALL_ONES) begin
            if (active_mode == MODE_FILL_DRAIN) begin
              q_n     = q >> 1;
              state_n = ST_DRAIN;
            end else begin
              boundary = 1'b1;
            end
          end else begin
            q_n = {q[WIDTH-2:0], 1'b1};
          end
        end
        ST_DRAIN: begin
          if (q == LSB_ONLY) boundary = 1'b1;
          else               q_n = q >> 1;
        end
        ST_WALK: begin
          if (q == MSB_ONLY) boundary = 1'b1;
          else               q_n = {q[WIDTH-2:0], q[WIDTH-1]};
        end
        ST_BLINK: begin
          if (q == ALL_ONES) boundary = 1'b1;
          else               q_n = ~q;
        end
        default: ;
      endcase

      // Every mode's normal wrap equals a restart at its own start value and
      // entry state, so a wrap and a mode change share one path.
      if (boundary) begin
        if (pending) begin
          next_mode = pending_mode;
          pending_n = 1'b0;
        end
        active_mode_n = next_mode;
        q_n           = WIDTH'(start_value(next_mode));
        state_n       = entry_state(next_mode);
        done_n        = 1'b1;
      end
    end

    // A request on a boundary edge is kept for the following boundary.
    if (bus.MODE_REQ) begin
      pending_mode_n = mode_t'(bus.MODE);
      pending_n      = 1'b1;
    end
  end

  assign bus.Q          = q;
  assign bus.PENDING    = pending;
  assign bus.CYCLE_DONE = done;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: a DIV=1 and a DIV=4 instance share the
// same stimulus; a reference model predicts both per cycle into a scoreboard.
module tb_led_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       mode_req = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_pattern_sequencer_if #(.WIDTH(8)) bus1 ();
  led_pattern_sequencer_if #(.WIDTH(8)) bus4 ();

  assign bus1.EN = en;
  assign bus1.MODE = mode;
  assign bus1.MODE_REQ = mode_req;
  assign bus4.EN = en;
  assign bus4.MODE = mode;
  assign bus4.MODE_REQ = mode_req;

  led_pattern_sequencer #(.WIDTH(8), .DIV(1)) dut1 (.CLK(clk), .RST(rst), .bus(bus1));
  led_pattern_sequencer #(.WIDTH(8), .DIV(4)) dut4 (.CLK(clk), .RST(rst), .bus(bus4));

  typedef struct packed {
    logic [7:0] q1; logic pend1; logic done1;
    logic [7:0] q4; logic pend4; logic done4;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  // Reference model: position k within the current mode's cycle.
  int unsigned m_cnt [2];
  int unsigned m_k [2];
  logic [1:0]  m_mode [2];
  logic [1:0]  m_pmode [2];
  logic        m_pend [2];

  function automatic int unsigned period(input logic [1:0] m);
    case (m)
      2'd0:    return 9;
      2'd1:    return 16;
      2'd2:    return 8;
      default: return 2;
    endcase
  endfunction

  function automatic int unsigned div_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [7:0] qval(input logic [1:0] m, input int unsigned k);
    int unsigned v;
    case (m)
      2'd0: v = (32'd1 << k) - 1;
      2'd1: v = (k <= 8) ? ((32'd1 << k) - 1) : (32'hFF >> (k - 8));
      2'd2: v = 32'd1 << k;
      default: v = (k % 2 == 1) ? 32'hFF : 32'h0;
    endcase
    return v[7:0];
  endfunction

  initial begin : ref_model
    logic tk;
    int unsigned k_n;
    logic [1:0] mode_n, pmode_n;
    logic pend_n, done_n;
    exp_t ent;
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_k[i] = 0; m_mode[i] = 2'd0; m_pmode[i] = 2'd0; m_pend[i] = 1'b0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 2; i++) begin
          m_cnt[i] = 0; m_k[i] = 0; m_mode[i] = 2'd0; m_pmode[i] = 2'd0; m_pend[i] = 1'b0;
        end
        sbq.delete();
      end else begin
        ent = '0;
        for (int i = 0; i < 2; i++) begin
          tk = en && (m_cnt[i] == div_of(i) - 1);
          k_n = m_k[i]; mode_n = m_mode[i]; pmode_n = m_pmode[i];
          pend_n = m_pend[i]; done_n = 1'b0;
          if (tk) begin
            if (m_k[i] + 1 == period(m_mode[i])) begin
              k_n = 0;
              done_n = 1'b1;
              if (m_pend[i]) begin
                mode_n = m_pmode[i];
                pend_n = 1'b0;
              end
            end else begin
              k_n = m_k[i] + 1;
            end
          end
          if (mode_req) begin
            pmode_n = mode;
            pend_n = 1'b1;
          end
          m_cnt[i] = tk ? 0 : (en ? m_cnt[i] + 1 : m_cnt[i]);
          m_k[i] = k_n; m_mode[i] = mode_n; m_pmode[i] = pmode_n; m_pend[i] = pend_n;
          if (i == 0) begin
            ent.q1 = qval(mode_n, k_n); ent.pend1 = pend_n; ent.done1 = done_n;
          end else begin
            ent.q4 = qval(mode_n, k_n); ent.pend4 = pend_n; ent.done4 = done_n;
          end
        end
        sbq.push_back(ent);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; mode_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== 10'b0) begin
      failures++;
      $display("FAIL reset_dut1 got q=%h pend=%b done=%b want 00/0/0", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE);
    end
    checks++;
    if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== 10'b0) begin
      failures++;
      $display("FAIL reset_dut4 got q=%h pend=%b done=%b want 00/0/0", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE);
    end
    rst = 1'b0;
    en = 1'b1;
    e = '0;
  endtask

  task automatic test_fill_clear();
    int done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      mode_req = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL fill_clear_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL fill_clear_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL fill_clear_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (bus1.CYCLE_DONE === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 2) begin
      failures++; $display("FAIL fill_clear_done_count got %0d want 2", done_seen);
    end
  endtask

  task automatic test_fill_drain();
    logic sent = 1'b0;
    logic saw_7f = 1'b0;
    for (int c = 0; c < 40; c++) begin
      mode_req = 1'b0;
      if (!sent && e.q1 == 8'h07) begin
        mode = 2'd1; mode_req = 1'b1; sent = 1'b1;
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL fill_drain_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL fill_drain_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL fill_drain_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (bus1.Q === 8'h7F) saw_7f = 1'b1;
    end
    mode_req = 1'b0;
    checks++;
    if ({sent, saw_7f} !== 2'b11) begin
      failures++; $display("FAIL fill_drain_reached got sent/7f=%b/%b want 1/1", sent, saw_7f);
    end
  endtask

  task automatic test_walk_div4();
    logic saw_80 = 1'b0;
    for (int c = 0; c < 150; c++) begin
      mode_req = (c == 0);
      mode = 2'd2;
      en = !(c >= 100 && c < 110);
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL walk_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL walk_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL walk_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (bus4.Q === 8'h80) saw_80 = 1'b1;
    end
    mode_req = 1'b0;
    en = 1'b1;
    checks++;
    if (saw_80 !== 1'b1) begin
      failures++; $display("FAIL walk_dut4_reached_80 got %b want 1", saw_80);
    end
  endtask

  task automatic test_req_on_boundary();
    logic sent = 1'b0;
    logic saw_ff = 1'b0;
    for (int c = 0; c < 30; c++) begin
      mode_req = 1'b0;
      if (!sent && e.q1 == 8'h80) begin
        mode = 2'd3; mode_req = 1'b1; sent = 1'b1;
        @(posedge clk); @(negedge clk);
        mode_req = 1'b0;
        checks++;
        if ({bus1.Q, bus1.PENDING} !== {8'h01, 1'b1}) begin
          failures++;
          $display("FAIL boundary_req_deferred got q=%h pend=%b want 01/1", bus1.Q, bus1.PENDING);
        end
      end else begin
        @(posedge clk); @(negedge clk);
      end
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL boundary_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL boundary_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL boundary_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (bus1.Q === 8'hFF) saw_ff = 1'b1;
    end
    checks++;
    if ({sent, saw_ff} !== 2'b11) begin
      failures++; $display("FAIL boundary_blink_entered got sent/ff=%b/%b want 1/1", sent, saw_ff);
    end
  endtask

  task automatic test_last_request_wins();
    int phase = 0;
    logic [7:0] prev_q = 8'h00;
    logic blink_seen = 1'b0;
    logic saw_7f = 1'b0;
    for (int c = 0; c < 60; c++) begin
      mode_req = 1'b0;
      if (c == 0) begin
        mode = 2'd2; mode_req = 1'b1;
      end else if (phase == 0 && e.q1 == 8'h01 && e.done1 && !e.pend1) begin
        mode = 2'd3; mode_req = 1'b1; phase = 1;
      end else if (phase == 1) begin
        mode = 2'd1; mode_req = 1'b1; phase = 2;
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL last_wins_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL last_wins_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL last_wins_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (phase == 2) begin
        if (prev_q == 8'h00 && bus1.Q === 8'hFF) blink_seen = 1'b1;
        if (bus1.Q === 8'h7F) saw_7f = 1'b1;
      end
      prev_q = bus1.Q;
    end
    mode_req = 1'b0;
    checks++;
    if ({blink_seen, saw_7f} !== 2'b01) begin
      failures++; $display("FAIL last_wins_mode got blink/7f=%b/%b want 0/1", blink_seen, saw_7f);
    end
  endtask

  task automatic test_async_reset();
    logic found = 1'b0;
    logic [7:0] prev_q = 8'h00;
    for (int c = 0; c < 40; c++) begin
      mode_req = 1'b0;
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL async_rst_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL async_rst_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL async_rst_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
      if (prev_q == 8'h7F && e.q1 == 8'h3F) begin
        found = 1'b1;
        break;
      end
      prev_q = e.q1;
    end
    checks++;
    if (found !== 1'b1) begin
      failures++; $display("FAIL async_rst_drain_3f got found=%b want 1", found);
    end
    // Request queued just before reset must be discarded.
    mode = 2'd2; mode_req = 1'b1;
    @(posedge clk);
    mode_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== 10'b0) begin
      failures++;
      $display("FAIL async_rst_now_dut1 got q=%h pend=%b done=%b want 00/0/0", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE);
    end
    checks++;
    if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== 10'b0) begin
      failures++;
      $display("FAIL async_rst_now_dut4 got q=%h pend=%b done=%b want 00/0/0", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    e = '0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (sbq.size() == 0) begin
        failures++; $display("FAIL restart_sb no expected entry");
      end else begin
        e = sbq.pop_front();
        if ({bus1.Q, bus1.PENDING, bus1.CYCLE_DONE} !== {e.q1, e.pend1, e.done1}) begin
          failures++;
          $display("FAIL restart_dut1 got %h/%b/%b want %h/%b/%b", bus1.Q, bus1.PENDING, bus1.CYCLE_DONE, e.q1, e.pend1, e.done1);
        end
        checks++;
        if ({bus4.Q, bus4.PENDING, bus4.CYCLE_DONE} !== {e.q4, e.pend4, e.done4}) begin
          failures++;
          $display("FAIL restart_dut4 got %h/%b/%b want %h/%b/%b", bus4.Q, bus4.PENDING, bus4.CYCLE_DONE, e.q4, e.pend4, e.done4);
        end
      end
    end
    checks++;
    if (bus1.Q !== 8'h07) begin
      failures++; $display("FAIL restart_fill_clear got q=%h want 07", bus1.Q);
    end
  endtask

  initial begin
    test_reset();
    test_fill_clear();
    test_fill_drain();
    test_walk_div4();
    test_req_on_boundary();
    test_last_request_wins();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Sequencer for the 8-bit LED bank of the pattern-demo board. It replaces the fixed "fill up, then clear" chaser with a mode-selectable controller. A prescaler paces the pattern steps. Mode-change requests are queued and take effect only at a pattern-cycle boundary, so a pattern is never cut mid-sweep. It sits between the board's mode-switch debouncer (MODE/MODE_REQ) and the LED output pins (Q).

## Interface
- WIDTH, 8 — LED count; legal range ≥ 2.
- DIV, 1 — clock cycles per pattern step; legal range ≥ 1. DIV=1 steps every cycle.
- CLK  in  1  — single clock; all state is updated on the rising edge.
- RST  in  1  — asynchronous, active-high reset.
- EN  in  1  — step enable. When low, the prescaler and Q freeze.
- MODE  in  2  — requested mode: 0 FILL_CLEAR, 1 FILL_DRAIN, 2 WALK, 3 BLINK.
- MODE_REQ  in  1  — 1-cycle strobe; MODE is sampled in the same cycle.
- Q  out  WIDTH  — LED pattern, registered.
- PENDING  out  1  — a queued mode change has not yet been applied.
- CYCLE_DONE  out  1  — 1-cycle pulse; the pattern has just wrapped to its start value.

## Operation
- Reset values:
  - Q=0, active mode=FILL_CLEAR, state=FILL, PENDING=0, CYCLE_DONE=0.
  - Prescaler count=0, pending mode=0.
- Prescaler:
  - cnt counts 0..DIV-1 while EN=1.
  - tick = EN && cnt==DIV-1. On a tick, cnt returns to 0.
  - When EN=0, cnt holds.
- FSM states: FILL, DRAIN, WALK, BLINK. Q changes only on a tick.
  - FILL, mode FILL_CLEAR: Q <= (Q<<1)|1. If Q is all ones, Q <= 0 instead; this is the boundary. Sequence 00,01,03,…,FF,00; period WIDTH+1 ticks.
  - FILL, mode FILL_DRAIN: same shift. If Q is all ones, Q <= Q>>1 and state <= DRAIN.
  - DRAIN: Q <= Q>>1. When Q==1, Q <= 0 and state <= FILL; this is the boundary. Period 2·WIDTH ticks.
  - WALK: Q <= Q rotated left by 1. The step 0x80→0x01 is the boundary. Start value 0x01; period WIDTH ticks.
  - BLINK: Q <= ~Q. The step FF→00 is the boundary. Start value 00; period 2 ticks.
- Mode requests:
  - MODE_REQ=1 writes pending_mode <= MODE and sets PENDING=1.
  - A later request before the boundary overwrites the earlier one; last request wins.
  - Requests are accepted regardless of EN.
- Boundary tick with PENDING=1:
  - active mode <= pending_mode.
  - Q <= start value of the new mode (0x01 for WALK, else 0).
  - state <= entry state of the new mode (FILL/FILL/WALK/BLINK).
  - PENDING <= 0.
- Boundary tick with PENDING=0: the normal wrap shown per state above.
- A request equal to the active mode is still queued and applied. The result is a restart at the start value, which is identical to a normal wrap.
- Simultaneous MODE_REQ and boundary tick: the request is captured but not applied at this boundary. PENDING stays 1 and the change applies at the next boundary.
- CYCLE_DONE is registered. It is high for exactly one cycle, in the cycle after every boundary tick, with or without a mode change.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge. Any pending request is discarded.

## Timing
- Q update latency: the clock edge at which tick=1 loads the next Q. The new value is visible in the following cycle.
- The first step after reset occurs at the DIV-th rising edge with EN=1.
- Mode change latency: from the MODE_REQ edge to the next boundary tick. Worst case is one full period of the current mode plus DIV-1 cycles.
- PENDING rises in the cycle after MODE_REQ and falls in the cycle after the applying boundary.

## Structure
- Package led_seq_pkg holds:
  - mode constants MODE_FILL_CLEAR=2'd0, MODE_FILL_DRAIN=2'd1, MODE_WALK=2'd2, MODE_BLINK=2'd3;
  - FSM state encoding;
  - a function returning the start value for a mode.
- Sub-module step_prescaler(CLK, RST, EN, TICK) is parameterised by DIV. Its count width is clog2(DIV), minimum 1.
- The top level holds the FSM, the pending register and the CYCLE_DONE register.

## Test plan
- Reset, then EN=1, DIV=1, default mode: Q = 00,01,03,07,…,FF,00. CYCLE_DONE pulses with Q=00 every 9 cycles. PENDING=0 throughout.
- MODE=1 with MODE_REQ while Q=07:
  - the FILL_CLEAR sweep completes (FF→00);
  - then Q = 01,03,…,FF,7F,3F,…,01,00, a 16-tick period;
  - PENDING is high from the request until the cycle after FF→00.
- DIV=4, MODE=2 requested: after the switch Q = 01,02,04,…,80,01, each value held 4 cycles. EN dropped for 10 cycles freezes Q and cnt; resuming continues exactly where it stopped.
- MODE_REQ MODE=3 on the same edge as the 80→01 WALK boundary: Q continues 01,02,… for one more WALK period, then 00,FF,00,FF.
- Two requests, MODE=3 then MODE=1, before one boundary: only FILL_DRAIN is entered and BLINK never appears.
- RST pulsed mid-DRAIN at Q=3F, between clock edges: Q=0, PENDING=0 and CYCLE_DONE=0 immediately. Operation restarts in FILL_CLEAR.
